// File: rtl/axi4_pkg.sv
// AXI4 address-channel types and helpers shared by the burst address generators.
// The next-address function lives here so the read and write paths compute beats identically.
package axi4_pkg;

  localparam int AXI4_BOUNDARY_BYTES = 4096;
  localparam int AXI4_MAX_ADDR_WIDTH = 64;

  typedef logic [7:0]                     axi4_len;
  typedef logic [2:0]                     axi4_size;
  typedef logic [AXI4_MAX_ADDR_WIDTH-1:0] axi4_addr;

  typedef enum logic [1:0] {
    AXI4_BURST_FIXED = 2'b00,
    AXI4_BURST_INCR  = 2'b01,
    AXI4_BURST_WRAP  = 2'b10,
    AXI4_BURST_UNDEF = 2'b11
  } axi4_burst;

  typedef enum logic [1:0] {
    AXI4_RESP_OKAY   = 2'b00,
    AXI4_RESP_EXOKAY = 2'b01,
    AXI4_RESP_SLVERR = 2'b10,
    AXI4_RESP_DECERR = 2'b11
  } axi4_resp;

  typedef enum logic {
    AGEN_IDLE  = 1'b0,
    AGEN_BURST = 1'b1
  } axi4_agen_state;

  function automatic axi4_addr axi4_bytes(input axi4_size size);
    return axi4_addr'(1) << size;
  endfunction

  function automatic bit axi4_burst_legal(input axi4_burst burst, input axi4_len len,
                                          input axi4_size size, input axi4_addr addr,
                                          input int data_bytes);
    axi4_addr bytes;
    axi4_addr aligned;
    axi4_addr span;
    bit       legal;
    bytes   = axi4_bytes(size);
    aligned = addr & ~(bytes - axi4_addr'(1));
    // Offset inside the 4KB page plus total burst bytes; beyond the page end is illegal for INCR.
    span    = axi4_addr'(aligned[11:0]) + (axi4_addr'(len) + axi4_addr'(1)) * bytes;
    legal   = 1'b1;
    if (burst == AXI4_BURST_UNDEF) legal = 1'b0;
    if (bytes > axi4_addr'(data_bytes)) legal = 1'b0;
    if (burst == AXI4_BURST_FIXED && len > 8'd15) legal = 1'b0;
    if (burst == AXI4_BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) legal = 1'b0;
    if (burst == AXI4_BURST_WRAP && (addr & (bytes - axi4_addr'(1))) != '0) legal = 1'b0;
    if (burst == AXI4_BURST_INCR && span > axi4_addr'(AXI4_BOUNDARY_BYTES)) legal = 1'b0;
    return legal;
  endfunction

  function automatic axi4_addr axi4_next_address(input axi4_burst burst, input axi4_addr cur,
                                                 input axi4_addr lower, input axi4_addr wsize,
                                                 input axi4_size size);
    axi4_addr bytes;
    axi4_addr stepped;
    axi4_addr result;
    bytes   = axi4_bytes(size);
    stepped = (cur & ~(bytes - axi4_addr'(1))) + bytes;
    result  = cur;
    case (burst)
      AXI4_BURST_INCR: result = stepped;
      AXI4_BURST_WRAP: result = (stepped == lower + wsize) ? lower : stepped;
      default:         result = cur;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/axi4_burst_address_generator.sv
// Expands one AXI4 AR/AW request into a registered per-beat address stream.
// Illegal bursts still emit len+1 beats, flagged SLVERR throughout.
module axi4_burst_address_generator
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [7:0]            in_len,
  input  logic [2:0]            in_size,
  input  axi4_burst             in_burst,
  input  logic [ID_WIDTH-1:0]   in_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [7:0]            out_beat,
  output logic                  out_last,
  output axi4_resp              out_resp
);

  axi4_agen_state        r_state;
  axi4_agen_state        w_nextState;
  logic [ADDR_WIDTH-1:0] r_curAddr;
  logic [ADDR_WIDTH-1:0] r_wrapLower;
  logic [ADDR_WIDTH-1:0] r_wrapSize;
  axi4_len               r_len;
  axi4_size              r_size;
  axi4_burst             r_burst;
  logic [ID_WIDTH-1:0]   r_id;
  axi4_len               r_beat;
  axi4_resp              r_resp;
  logic                  r_outValid;
  logic                  r_last;

  logic                  w_fire;
  logic                  w_accept;
  logic                  w_legal;
  axi4_addr              w_inAddrExt;
  axi4_addr              w_wsizeExt;
  logic [ADDR_WIDTH-1:0] w_wsize;
  logic [ADDR_WIDTH-1:0] w_wrapLower;
  axi4_burst             w_loadBurst;
  logic [ADDR_WIDTH-1:0] w_nextAddr;

  // A new request can be taken in the same cycle the previous last beat leaves.
  always_comb begin
    w_fire      = r_outValid & out_ready;
    in_ready    = (r_state == AGEN_IDLE) | (w_fire & r_last);
    w_accept    = in_valid & in_ready;
    w_nextState = r_state;
    case (r_state)
      AGEN_IDLE:  if (w_accept) w_nextState = AGEN_BURST;
      AGEN_BURST: if (w_fire & r_last & ~w_accept) w_nextState = AGEN_IDLE;
      default:    w_nextState = AGEN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= AGEN_IDLE;
    else     r_state <= w_nextState;
  end

  // Error bursts walk as FIXED, except a page-crossing INCR, which keeps its INCR addresses.
  always_comb begin
    w_inAddrExt = axi4_addr'(in_addr);
    w_legal     = axi4_burst_legal(in_burst, in_len, in_size, w_inAddrExt, DATA_BYTES);
    w_wsizeExt  = (axi4_addr'(in_len) + axi4_addr'(1)) << in_size;
    w_wsize     = ADDR_WIDTH'(w_wsizeExt);
    w_wrapLower = in_addr & ~(w_wsize - ADDR_WIDTH'(1));
    w_loadBurst = AXI4_BURST_FIXED;
    if (w_legal)
      w_loadBurst = in_burst;
    else if (in_burst == AXI4_BURST_INCR && axi4_bytes(in_size) <= axi4_addr'(DATA_BYTES))
      w_loadBurst = AXI4_BURST_INCR;
    w_nextAddr = ADDR_WIDTH'(axi4_next_address(r_burst, axi4_addr'(r_curAddr),
                                               axi4_addr'(r_wrapLower),
                                               axi4_addr'(r_wrapSize), r_size));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_curAddr   <= '0;
      r_wrapLower <= '0;
      r_wrapSize  <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= AXI4_BURST_FIXED;
      r_id        <= '0;
      r_beat      <= '0;
      r_resp      <= AXI4_RESP_OKAY;
      r_outValid  <= 1'b0;
      r_last      <= 1'b0;
    end else if (w_accept) begin
      r_curAddr   <= in_addr;
      r_wrapLower <= w_wrapLower;
      r_wrapSize  <= w_wsize;
      r_len       <= in_len;
      r_size      <= in_size;
      r_burst     <= w_loadBurst;
      r_id        <= in_id;
      r_beat      <= '0;
      r_resp      <= w_legal ? AXI4_RESP_OKAY : AXI4_RESP_SLVERR;
      r_outValid  <= 1'b1;
      r_last      <= (in_len == 8'd0);
    end else if (w_fire) begin
      if (r_last) begin
        r_outValid <= 1'b0;
      end else begin
        r_curAddr <= w_nextAddr;
        r_beat    <= r_beat + 8'd1;
        r_last    <= ((r_beat + 8'd1) == r_len);
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_addr  = r_curAddr;
  assign out_id    = r_id;
  assign out_beat  = r_beat;
  assign out_last  = r_last;
  assign out_resp  = r_resp;

endmodule

// File: tb/tb_axi4_burst_address_generator.sv
// Scoreboard bench: requests push modelled beats into a queue, a monitor pops and compares.
// Directed cases cover the documented examples; a random phase covers the rest.
module tb_axi4_burst_address_generator;
  import axi4_pkg::*;

  localparam int AW = 32;
  localparam int IW = 4;
  localparam int DB = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    beat;
    logic          last;
    axi4_resp      resp;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_len;
  logic [2:0]    in_size;
  axi4_burst     in_burst;
  logic [IW-1:0] in_id;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [IW-1:0] out_id;
  logic [7:0]    out_beat;
  logic          out_last;
  axi4_resp      out_resp;

  int    checkCount = 0;
  int    errorCount = 0;
  beat_t expQ[$];
  int    readyMode = 0;
  logic  forceReady = 1'b1;

  axi4_burst_address_generator #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_BYTES(DB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_len(in_len),
    .in_size(in_size), .in_burst(in_burst), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_id(out_id),
    .out_beat(out_beat), .out_last(out_last), .out_resp(out_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic compareBeat(input string name, input beat_t act, input beat_t exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual addr=0x%0h id=%0d beat=%0d last=%0b resp=%0d required addr=0x%0h id=%0d beat=%0d last=%0b resp=%0d",
               name, act.addr, act.id, act.beat, act.last, act.resp,
               exp.addr, exp.id, exp.beat, exp.last, exp.resp);
    end
  endtask

  // Reference model: beats derived directly from the burst rules with plain arithmetic.
  function automatic void pushExpected(input logic [AW-1:0] a, input logic [7:0] len,
                                       input logic [2:0] size, input axi4_burst b,
                                       input logic [IW-1:0] id);
    int unsigned   bytes;
    int unsigned   beats;
    int unsigned   wsize;
    logic [AW-1:0] aligned;
    logic [AW-1:0] lower;
    logic [AW-1:0] addrN;
    axi4_burst     walk;
    bit            err;
    beat_t         e;
    bytes   = 1 << size;
    beats   = int'(len) + 1;
    aligned = a & ~(bytes - 1);
    err     = 0;
    if (b == AXI4_BURST_UNDEF) err = 1;
    if (bytes > DB) err = 1;
    if (b == AXI4_BURST_FIXED && beats > 16) err = 1;
    if (b == AXI4_BURST_WRAP && !(beats == 2 || beats == 4 || beats == 8 || beats == 16)) err = 1;
    if (b == AXI4_BURST_WRAP && (a % bytes) != 0) err = 1;
    if (b == AXI4_BURST_INCR && ((aligned % 4096) + beats * bytes) > 4096) err = 1;
    if (!err) walk = b;
    else if (b == AXI4_BURST_INCR && bytes <= DB) walk = AXI4_BURST_INCR;
    else walk = AXI4_BURST_FIXED;
    wsize = beats * bytes;
    lower = (walk == AXI4_BURST_WRAP) ? (a - (a % wsize)) : a;
    for (int n = 0; n < int'(beats); n++) begin
      case (walk)
        AXI4_BURST_INCR: addrN = (n == 0) ? a : aligned + AW'(n * bytes);
        AXI4_BURST_WRAP: addrN = lower + AW'(((a - lower) + n * bytes) % wsize);
        default:         addrN = a;
      endcase
      e.addr = addrN;
      e.id   = id;
      e.beat = 8'(n);
      e.last = (n == int'(beats) - 1);
      e.resp = err ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
      expQ.push_back(e);
    end
  endfunction

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [7:0] len,
                               input logic [2:0] size, input axi4_burst b,
                               input logic [IW-1:0] id);
    int waited = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_len   = len;
    in_size  = size;
    in_burst = b;
    in_id    = id;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 2000) break;
    end
    if (waited > 2000) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL accept_timeout actual in_ready=0 required in_ready=1 within 2000 cycles");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      pushExpected(a, len, size, b, id);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL drain_timeout actual pending=%0d required pending=0", expQ.size());
      expQ.delete();
    end
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 9) < 7);
        default: out_ready = forceReady;
      endcase
    end
  end

  // Monitor: consumes modelled beats on each handshake and checks stall stability and bubbles.
  initial begin
    beat_t held;
    beat_t cur;
    beat_t exp;
    bit    prevStalled = 0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {out_addr, out_id, out_beat, out_last, out_resp};
      if (rst) begin
        prevStalled = 0;
      end else begin
        if (expQ.size() != 0) checkOutput("no_bubble_valid", 64'(out_valid), 64'd1);
        if (prevStalled) compareBeat("stall_stable", cur, held);
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpected_beat actual addr=0x%0h beat=%0d required no beat", out_addr, out_beat);
          end else begin
            exp = expQ.pop_front();
            compareBeat("beat", cur, exp);
          end
        end
        prevStalled = out_valid && !out_ready;
        held = cur;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual still running required finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [7:0]    rl;
    logic [2:0]    rs;
    axi4_burst     rb;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_len   = '0;
    in_size  = '0;
    in_burst = AXI4_BURST_FIXED;
    in_id    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_addr", 64'(out_addr), 64'd0);
    checkOutput("reset_out_beat", 64'(out_beat), 64'd0);
    checkOutput("reset_out_last", 64'(out_last), 64'd0);
    checkOutput("reset_out_resp", 64'(out_resp), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed bursts, back-to-back");
    applyStimulus(32'h1002, 8'd3, 3'd2, AXI4_BURST_INCR, 4'd1);
    applyStimulus(32'h1008, 8'd3, 3'd2, AXI4_BURST_WRAP, 4'd2);
    applyStimulus(32'h0040, 8'd2, 3'd2, AXI4_BURST_FIXED, 4'd3);
    applyStimulus(32'h0040, 8'd2, 3'd2, AXI4_BURST_WRAP, 4'd4);
    applyStimulus(32'h0080, 8'd1, 3'd2, AXI4_BURST_UNDEF, 4'd5);
    applyStimulus(32'h0FFC, 8'd1, 3'd2, AXI4_BURST_INCR, 4'd6);
    applyStimulus(32'h0100, 8'd1, 3'd3, AXI4_BURST_INCR, 4'd7);
    waitDrain();

    $display("[TB] stall on beat 1");
    readyMode  = 2;
    forceReady = 1'b1;
    applyStimulus(32'h0300, 8'd3, 3'd2, AXI4_BURST_INCR, 4'd8);
    @(posedge clk);
    #1 forceReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 forceReady = 1'b1;
    waitDrain();
    readyMode = 0;

    $display("[TB] async reset mid-burst");
    applyStimulus(32'h0200, 8'd3, 3'd2, AXI4_BURST_INCR, 4'd9);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_async_out_valid", 64'(out_valid), 64'd0);
    expQ.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("rst_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_release_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(32'h0020, 8'd0, 3'd2, AXI4_BURST_INCR, 4'd10);
    waitDrain();

    $display("[TB] random bursts");
    readyMode = 1;
    for (int i = 0; i < 40; i++) begin
      rb = axi4_burst'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       rl = 8'd0;
        1:       rl = 8'd1;
        2:       rl = 8'd3;
        3:       rl = 8'd7;
        4:       rl = 8'd15;
        default: rl = 8'($urandom_range(0, 255));
      endcase
      ra = 32'($urandom);
      if ($urandom_range(0, 1) == 1) ra = ra & ~((32'd1 << rs) - 32'd1);
      if ($urandom_range(0, 3) == 0) ra[11:4] = 8'hFF;
      applyStimulus(ra, rl, rs, rb, 4'($urandom_range(0, 15)));
    end
    readyMode = 0;
    waitDrain();
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
